ro_freq_meter: RTL and testbench

//  Measurement stage directly downstream of the ring-oscillator mux cell.

---
 rtl/ro_meter_pkg.sv | 21 ++
 rtl/ro_sync_edge.sv | 26 ++
 rtl/ro_freq_meter.sv | 122 ++++++++++++
 tb/tb_ro_freq_meter.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ro_meter_pkg.sv
// rtl/ro_meter_pkg.sv - shared state encoding and constants for the RO frequency meter
package ro_meter_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    GATE   = 2'd2,
    DONE   = 2'd3
  } meter_state_t;

  localparam logic RO_SEL_RING = 1'b0;
  localparam logic RO_SEL_HOLD = 1'b1;

  localparam int DEF_GATE_CYCLES   = 100000;
  localparam int DEF_SETTLE_CYCLES = 16;

  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/ro_sync_edge.sv
// rtl/ro_sync_edge.sv - multi-flop synchronizer for the async RO output plus rising-edge pulse
module ro_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic async_in,
  output logic rise
);

  (* ASYNC_REG = "TRUE" *) logic [SYNC_STAGES-1:0] sync;
  logic prev;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], async_in};
      prev <= sync[SYNC_STAGES-1];
    end
  end

  assign rise = sync[SYNC_STAGES-1] & ~prev;

endmodule

// File: rtl/ro_freq_meter.sv
// rtl/ro_freq_meter.sv - ring-oscillator edge counter over a fixed gate window
module ro_freq_meter
  import ro_meter_pkg::*;
#(
  parameter int GATE_CYCLES   = DEF_GATE_CYCLES,
  parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
  parameter int CNT_W         = 32,
  parameter int SYNC_STAGES   = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             ro_clk,
  output logic             ro_en,
  output logic             ro_sel,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] count,
  output logic             overflow
);

  localparam int TMR_W = $clog2(max_int(GATE_CYCLES, SETTLE_CYCLES) + 1);
  localparam logic [TMR_W-1:0] SETTLE_LAST = TMR_W'(SETTLE_CYCLES - 1);
  localparam logic [TMR_W-1:0] GATE_LAST   = TMR_W'(GATE_CYCLES - 1);

  meter_state_t     state;
  logic [TMR_W-1:0] timer;
  logic [CNT_W-1:0] counter;
  logic [CNT_W-1:0] counter_nxt;
  logic             sat;
  logic             sat_nxt;
  logic             rise;

  ro_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk      (clk),
    .rst      (rst),
    .async_in (ro_clk),
    .rise     (rise)
  );

  // Counter sticks at all-ones; the flag marks that the figure is a lower bound.
  always_comb begin
    counter_nxt = counter;
    sat_nxt     = sat;
    if (rise && !(&counter)) begin
      counter_nxt = counter + 1'b1;
      sat_nxt     = &(counter + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      timer    <= '0;
      counter  <= '0;
      sat      <= 1'b0;
      ro_en    <= 1'b0;
      ro_sel   <= RO_SEL_HOLD;
      busy     <= 1'b0;
      done     <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !abort) begin
            state  <= SETTLE;
            timer  <= '0;
            busy   <= 1'b1;
            ro_en  <= 1'b1;
            ro_sel <= RO_SEL_RING;
          end
        end
        SETTLE: begin
          counter <= '0;
          sat     <= 1'b0;
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            ro_en  <= 1'b0;
            ro_sel <= RO_SEL_HOLD;
          end else if (timer == SETTLE_LAST) begin
            state <= GATE;
            timer <= '0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        GATE: begin
          if (abort) begin
            state  <= IDLE;
            busy   <= 1'b0;
            ro_en  <= 1'b0;
            ro_sel <= RO_SEL_HOLD;
          end else begin
            counter <= counter_nxt;
            sat     <= sat_nxt;
            // Publish on the last gate edge so the result is valid alongside done.
            if (timer == GATE_LAST) begin
              state    <= DONE;
              count    <= counter_nxt;
              overflow <= sat_nxt;
              done     <= 1'b1;
              busy     <= 1'b0;
              ro_en    <= 1'b0;
              ro_sel   <= RO_SEL_HOLD;
            end else begin
              timer <= timer + 1'b1;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ro_freq_meter.sv
// tb/tb_ro_freq_meter.sv - self-checking bench: timestamp-based model plus directed scenarios
module tb_ro_freq_meter;

  localparam int S    = 16;
  localparam int SYNC = 2;
  localparam int HIST = 16384;

  logic clk = 1'b0;
  logic rst, start, abort, ro_clk;
  logic ro_en_a, ro_sel_a, busy_a, done_a, ovf_a;
  logic ro_en_b, ro_sel_b, busy_b, done_b, ovf_b;
  logic [31:0] count_a;
  logic [3:0]  count_b;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ro_freq_meter #(.GATE_CYCLES(1000), .SETTLE_CYCLES(S), .CNT_W(32), .SYNC_STAGES(SYNC)) dut_a (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ro_clk(ro_clk),
    .ro_en(ro_en_a), .ro_sel(ro_sel_a), .busy(busy_a), .done(done_a),
    .count(count_a), .overflow(ovf_a)
  );

  ro_freq_meter #(.GATE_CYCLES(100), .SETTLE_CYCLES(S), .CNT_W(4), .SYNC_STAGES(SYNC)) dut_b (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .ro_clk(ro_clk),
    .ro_en(ro_en_b), .ro_sel(ro_sel_b), .busy(busy_b), .done(done_b),
    .count(count_b), .overflow(ovf_b)
  );

  // RO stimulus: square wave of ro_period clk cycles, or a static level when ro_period is 0
  int ro_period = 0;
  logic ro_level = 1'b0;
  int ph = 0;
  always @(negedge clk) begin
    if (ro_period > 0) begin
      ph = (ph + 1) % ro_period;
      ro_clk = (ph < ro_period / 2);
    end else begin
      ro_clk = ro_level;
    end
  end

  task automatic check(input string name, input longint got, input longint exp);
    n_cmp++;
    if (got != exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", name, got, exp);
    end
  endtask

  // Model: a run is a timestamp t0; every output follows from the edge offset r = t - t0
  int      gate_len [2] = '{1000, 100};
  longint  max_cnt  [2] = '{64'hFFFF_FFFF, 64'd15};
  bit      m_active [2];
  int      m_t0     [2];
  longint  m_acc    [2];
  longint  m_count  [2];
  bit      m_ovf    [2];
  bit      s_hist   [HIST];
  int      t = 0;
  bit      chk_en = 0;

  function automatic bit rise_at(input int e);
    if (e < SYNC + 1) return 1'b0;
    return s_hist[e-SYNC] & ~s_hist[e-SYNC-1];
  endfunction

  always @(posedge clk) begin
    #1;
    t++;
    if (t < HIST) s_hist[t] = ro_clk;
    for (int d = 0; d < 2; d++) begin
      int r;
      r = t - m_t0[d];
      if (rst) begin
        m_active[d] = 0;
        m_count[d]  = 0;
        m_ovf[d]    = 0;
      end else if (m_active[d]) begin
        if (abort && r <= S + gate_len[d]) begin
          m_active[d] = 0;
        end else begin
          if (r >= S + 1 && r <= S + gate_len[d] && rise_at(t) && m_acc[d] < max_cnt[d])
            m_acc[d]++;
          if (r == S + gate_len[d]) begin
            m_count[d] = m_acc[d];
            m_ovf[d]   = (m_acc[d] == max_cnt[d]);
          end
          if (r == S + gate_len[d] + 1) m_active[d] = 0;
        end
      end else if (start && !abort) begin
        m_active[d] = 1;
        m_t0[d]     = t;
        m_acc[d]    = 0;
      end
    end
    if (rst) chk_en = 1;
    if (chk_en) begin
      for (int d = 0; d < 2; d++) begin
        logic [36:0] exp_v, got_v;
        int  r;
        bit  b, dn;
        r  = t - m_t0[d];
        b  = m_active[d] && (r < S + gate_len[d]);
        dn = m_active[d] && (r == S + gate_len[d]);
        exp_v = {b, dn, ~b, b, m_ovf[d], m_count[d][31:0]};
        if (d == 0) got_v = {busy_a, done_a, ro_sel_a, ro_en_a, ovf_a, count_a};
        else        got_v = {busy_b, done_b, ro_sel_b, ro_en_b, ovf_b, 28'd0, count_b};
        n_cmp++;
        if (got_v !== exp_v) begin
          n_bad++;
          $display("FAIL model_%s t=%0d got={busy,done,sel,en,ovf,count}=%h exp=%h",
                   (d == 0) ? "a" : "b", t, got_v, exp_v);
        end
      end
    end
  end

  task automatic pulse_start();
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
  endtask

  // Returns the negedge index (1 = just after the start-sampling edge) where done_a is first seen
  task automatic wait_done_a(output int k);
    k = 1;
    while (!done_a && k < 3000) begin
      @(negedge clk);
      k++;
    end
  endtask

  initial begin
    int lat, dn;
    rst = 1'b1; start = 1'b0; abort = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_count", count_a, 0);
    check("reset_ro_sel", ro_sel_a, 1);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // 1: nominal run, period 10
    ro_period = 10;
    pulse_start();
    wait_done_a(lat);
    check("t1_latency", lat, 1017);
    check("t1_count_in_range", (count_a >= 99 && count_a <= 101), 1);
    check("t1_count_a", count_a, 100);
    check("t1_ovf_a", ovf_a, 0);
    check("t1_count_b", count_b, 10);

    // 4: abort 50 cycles into GATE
    repeat (5) @(negedge clk);
    pulse_start();
    repeat (S + 49) @(negedge clk);
    abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    check("t4_busy", busy_a, 0);
    check("t4_ro_sel", ro_sel_a, 1);
    check("t4_ro_en", ro_en_a, 0);
    dn = 0;
    for (int i = 0; i < 1100; i++) begin
      @(negedge clk);
      if (done_a) dn++;
    end
    check("t4_no_done", dn, 0);
    check("t4_count_kept_a", count_a, 100);
    check("t4_count_kept_b", count_b, 10);

    // 2: saturation in the 4-bit instance, period 4
    ro_period = 4;
    pulse_start();
    wait_done_a(lat);
    check("t2_latency", lat, 1017);
    check("t2_count_a", count_a, 250);
    check("t2_ovf_a", ovf_a, 0);
    check("t2_count_b", count_b, 15);
    check("t2_ovf_b", ovf_b, 1);
    @(negedge clk);
    check("t2_done_width", done_a, 0);

    // 3: static RO, low then high
    ro_period = 0; ro_level = 1'b0;
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done_a(lat);
    check("t3_low_done", lat, 1017);
    check("t3_low_count", count_a, 0);
    check("t3_low_ovf_b", ovf_b, 0);
    ro_level = 1'b1;
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done_a(lat);
    check("t3_high_done", lat, 1017);
    check("t3_high_count", count_a, 0);
    check("t3_high_count_b", count_b, 0);

    // start and abort together in IDLE
    @(negedge clk); start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    check("start_abort_idle", busy_a, 0);

    // 5: repeated start while busy
    ro_period = 10;
    pulse_start();
    for (int i = 0; i < 10; i++) begin
      repeat (50) @(negedge clk);
      start = 1'b1;
      @(negedge clk); start = 1'b0;
    end
    dn = 0;
    for (int i = 0; i < 1200; i++) begin
      @(negedge clk);
      if (done_a) dn++;
    end
    check("t5_one_done", dn, 1);
    pulse_start();
    wait_done_a(lat);
    check("t5_fresh_latency", lat, 1017);
    check("t5_fresh_count", count_a, 100);

    // 6: reset mid-GATE, then a normal run
    repeat (5) @(negedge clk);
    pulse_start();
    repeat (S + 300) @(negedge clk);
    rst = 1'b1;
    @(negedge clk); rst = 1'b0;
    check("t6_busy", busy_a, 0);
    check("t6_ro_sel", ro_sel_a, 1);
    check("t6_ro_en", ro_en_a, 0);
    check("t6_count", count_a, 0);
    check("t6_count_b", count_b, 0);
    repeat (5) @(negedge clk);
    pulse_start();
    wait_done_a(lat);
    check("t6_after_latency", lat, 1017);
    check("t6_after_count", count_a, 100);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
